// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its byte serializer.
// Each baud code maps to a bit period expressed in Clk cycles.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [2:0] BAUD_CODE_0 = 3'd0;
  localparam logic [2:0] BAUD_CODE_1 = 3'd1;
  localparam logic [2:0] BAUD_CODE_2 = 3'd2;
  localparam logic [2:0] BAUD_CODE_3 = 3'd3;
  localparam logic [2:0] BAUD_CODE_4 = 3'd4;

  localparam int DIV_W = 7;

  // Unassigned codes fall back to the slowest rate.
  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] code);
    logic [DIV_W-1:0] div;
    case (code)
      BAUD_CODE_0: div = 7'd64;
      BAUD_CODE_1: div = 7'd32;
      BAUD_CODE_2: div = 7'd16;
      BAUD_CODE_3: div = 7'd8;
      BAUD_CODE_4: div = 7'd4;
      default:     div = 7'd64;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serializer: start bit, 8 data bits LSB first, stop bit.
// A new byte starts only once send_en is seen outside a tx_done cycle; dropping send_en aborts.
module uart_byte_tx
  import uart_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Data,
  input  logic [2:0] baud_set,
  input  logic       send_en,
  output logic       uart_tx,
  output logic       tx_done
);

  logic             active;
  logic [8:0]       shift;
  logic [3:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_val;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      active  <= 1'b0;
      shift   <= '1;
      bit_cnt <= '0;
      div_cnt <= '0;
      div_val <= baud_div(BAUD_CODE_0);
      uart_tx <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!active) begin
        uart_tx <= 1'b1;
        // send_en is still high during the tx_done cycle; do not restart on it.
        if (send_en && !tx_done) begin
          active  <= 1'b1;
          shift   <= {1'b1, Data};
          uart_tx <= 1'b0;
          div_val <= baud_div(baud_set);
          div_cnt <= '0;
          bit_cnt <= '0;
        end
      end else if (!send_en) begin
        active  <= 1'b0;
        uart_tx <= 1'b1;
      end else if (div_cnt == div_val - 7'd1) begin
        div_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active  <= 1'b0;
          tx_done <= 1'b1;
          uart_tx <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          uart_tx <= shift[0];
          shift   <= {1'b1, shift[8:1]};
        end
      end else begin
        div_cnt <= div_cnt + 7'd1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding two byte requesters into one UART serializer.
// Define UART_ARB_TIMEOUT_EN to enable the SEND-state watchdog (err_timeout).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int GAP_CYCLES     = 0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [2:0] baud_set,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       grant_id,
  output logic       err_timeout
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state;
  logic [7:0]       data_q;
  logic [2:0]       baud_q;
  logic             last_grant;
  logic [GAP_W-1:0] gap_cnt;
  logic             send_en;
  logic             tx_done;
  logic             winner;
  logic             accept;
  logic             timeout_hit;
  logic [7:0]       accept_data;

  // Ties go to whoever was not served last; a lone valid always wins.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = ~last_grant;
    end else if (req1_valid) begin
      winner = 1'b1;
    end
  end

  assign accept      = Reset_n && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready  = accept && !winner;
  assign req1_ready  = accept && winner;
  assign accept_data = winner ? req1_data : req0_data;
  assign send_en     = (state == SEND);
  assign tx_busy     = (state != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign timeout_hit = (state == SEND) && !tx_done &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (!Reset_n || (state != SEND)) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign err_timeout = timeout_hit;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= IDLE;
      data_q     <= '0;
      baud_q     <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q   <= accept_data;
            baud_q   <= baud_set;
            grant_id <= winner;
            state    <= SEND;
          end
        end
        SEND: begin
          // A watchdog abort counts as completion for round-robin fairness.
          if (tx_done || timeout_hit) begin
            last_grant <= grant_id;
            gap_cnt    <= '0;
            state      <= ((GAP_CYCLES == 0) || timeout_hit) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_byte_tx u_byte_tx (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Data     (data_q),
    .baud_set (baud_q),
    .send_en  (send_en),
    .uart_tx  (uart_tx),
    .tx_done  (tx_done)
  );

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000, the maximum number of SEND-state cycles before an abort.
REQ-002 SHALL have parameter GAP_CYCLES, default 0, the number of idle cycles inserted after each byte completes.
REQ-003 SHALL have port Clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-004 SHALL have port Reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port baud_set, input, 3 bits: baud code, sampled when a byte is accepted.
REQ-006 SHALL have ports req0_valid (input, 1), req0_data (input, 8) and req0_ready (output, 1) forming the requester-0 byte handshake.
REQ-007 SHALL have ports req1_valid (input, 1), req1_data (input, 8) and req1_ready (output, 1) forming the requester-1 byte handshake.
REQ-008 SHALL have port uart_tx, output, 1 bit: the serial line, idle high.
REQ-009 SHALL have port tx_busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 SHALL have port grant_id, output, 1 bit: the requester that owns the byte in flight.
REQ-011 SHALL have port err_timeout, output, 1 bit: a one-cycle pulse on a watchdog abort.

Function
REQ-012 SHALL implement FSM states IDLE, SEND and GAP.
REQ-013 SHALL raise at most one reqN_ready at a time, only in IDLE, and only for the arbitration winner.
REQ-014 SHALL, when only one reqN_valid is high in IDLE, make that requester the winner.
REQ-015 SHALL, when both valids are high in IDLE, give the grant to the requester not granted last (round-robin).
REQ-016 SHALL treat valid&&ready in the same cycle as acceptance: latch data, baud_set and grant_id, and go IDLE->SEND on the next edge.
REQ-017 SHALL, in SEND, hold send_en=1 and a stable data byte and baud code to the sub-module until its tx_done pulse is seen.
REQ-018 SHALL, on tx_done, deassert send_en in the next cycle and enter GAP, or enter IDLE directly when GAP_CYCLES=0.
REQ-019 SHALL count GAP_CYCLES cycles in GAP and then return to IDLE.
REQ-020 SHALL allow back-to-back accepts one cycle apart when GAP_CYCLES=0: tx_done -> IDLE (ready) -> SEND.
REQ-021 SHALL ignore changes to baud_set and reqN_data while in SEND or GAP.
REQ-022 SHALL not drop a requester that deasserts valid before ready: no acceptance occurs and no state is affected.
REQ-023 SHALL ignore any tx_done that arrives outside SEND.

Reset
REQ-024 SHALL, while Reset_n=0 at a rising Clk edge, force: state=IDLE, both ready=0, tx_busy=0, grant_id=0, err_timeout=0, send_en=0, uart_tx=1, counters=0, last_grant=1 (requester 0 wins the first tie).
REQ-025 SHALL, on reset asserted mid-SEND, abort the byte immediately with no tx_done-driven transition afterwards.

Configuration
REQ-026 SHALL, with macro UART_ARB_TIMEOUT_EN defined, count SEND cycles and, on reaching TIMEOUT_CYCLES without tx_done, drop send_en, pulse err_timeout for one cycle, go to IDLE and update last_grant as if the byte completed.
REQ-027 SHALL, without UART_ARB_TIMEOUT_EN, omit the watchdog counter, tie err_timeout to 0 and wait in SEND indefinitely.

Structure
REQ-028 SHALL place the state enum (IDLE/SEND/GAP) and the baud code constants 0..4 in shared package uart_pkg.
REQ-029 SHALL instantiate exactly one uart_byte_tx sub-module (Clk, Reset_n, Data, baud_set, send_en, uart_tx, tx_done) driven by the latched registers.

Verification
REQ-030 SHALL verify a single byte: baud_set=4, req0 sends 0xAB -> uart_tx shows start, bits LSB-first 1,1,0,1,0,1,0,1, stop; one tx_done; tx_busy returns to 0.
REQ-031 SHALL verify contention after reset: both requesters valid (0x2E, 0x55) -> 0x2E sent first with grant_id=0, then 0x55 with grant_id=1.
REQ-032 SHALL verify sustained contention: both valid for 4 bytes -> grants alternate 0,1,0,1 and neither requester is granted twice in a row.
REQ-033 SHALL verify GAP_CYCLES=16: the next ready rises exactly 17 cycles after the tx_done cycle.
REQ-034 SHALL verify data stability: baud_set/data changed mid-SEND -> serial output unaffected and the new baud applies only to the next byte.
REQ-035 SHALL verify the watchdog: UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, sub-module tx_done forced low -> err_timeout pulses at SEND cycle 100, FSM returns to IDLE, and the other requester is granted next.
